// File: rtl/serial_link_controller_if.sv
// Processor-side port bundle of the serial link controller.
//
// Groups the parallel transmit/receive handshake between the processor I/O
// and the serial link controller:
//   tx_data            byte to send (processor data_bus_out)
//   transmit_enable    send request
//   tx_busy            transmit frame in progress
//   character_sent     one-cycle pulse when a frame has been fully sent
//   rx_data            last received byte (processor data_bus_in)
//   character_received new byte is held in rx_data
//   load               processor has read rx_data
//   rx_overrun         sticky: byte delivered while previous one unread
//   framing_error      sticky: stop bit sampled low
// The master modport is the processor side, the slave modport the controller.
interface serial_link_controller_if;
    logic [7:0] tx_data;
    logic       transmit_enable;
    logic       tx_busy;
    logic       character_sent;
    logic [7:0] rx_data;
    logic       character_received;
    logic       load;
    logic       rx_overrun;
    logic       framing_error;

    modport master (
        output tx_data,
        output transmit_enable,
        output load,
        input  tx_busy,
        input  character_sent,
        input  rx_data,
        input  character_received,
        input  rx_overrun,
        input  framing_error
    );

    modport slave (
        input  tx_data,
        input  transmit_enable,
        input  load,
        output tx_busy,
        output character_sent,
        output rx_data,
        output character_received,
        output rx_overrun,
        output framing_error
    );
endinterface

// File: rtl/serial_link_controller.sv
// Serial link controller for the battleship board-to-board link.
//
// Serializes bytes handed over by the processor and deserializes bytes coming
// from the opponent's board. Frame format: 1 start bit (low), 8 data bits LSB
// first, 1 stop bit (high); every bit lasts CLKS_PER_BIT clock cycles.
//
// Ports:
//   clk_clk        system clock, all state on its rising edge
//   reset_reset_n  asynchronous active-low reset, abandons partial frames
//   proc           processor handshake (serial_link_controller_if.slave)
//   serial_in      line from the opponent (asynchronous, idle high)
//   serial_out     line to the opponent (registered, idle high)
module serial_link_controller #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                           clk_clk,
    input  logic                           reset_reset_n,
    serial_link_controller_if.slave        proc,
    input  logic                           serial_in,
    output logic                           serial_out
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    // The state machine spends the detection cycle at count 0, so stopping at
    // MID-1 lands the start-bit check on the bit midpoint.
    localparam logic [CW-1:0] MID_M1  = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    state_t        tx_state_q;
    logic [CW-1:0] tx_cnt_q;
    logic [2:0]    tx_bit_q;
    logic [7:0]    tx_shift_q;
    logic          serial_out_q;
    logic          tx_busy_q;
    logic          char_sent_q;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            tx_state_q   <= IDLE;
            tx_cnt_q     <= '0;
            tx_bit_q     <= '0;
            tx_shift_q   <= '0;
            serial_out_q <= 1'b1;
            tx_busy_q    <= 1'b0;
            char_sent_q  <= 1'b0;
        end else begin
            char_sent_q <= 1'b0;
            case (tx_state_q)
                IDLE: begin
                    if (proc.transmit_enable) begin
                        tx_shift_q   <= proc.tx_data;
                        tx_cnt_q     <= '0;
                        tx_bit_q     <= '0;
                        serial_out_q <= 1'b0;
                        tx_busy_q    <= 1'b1;
                        tx_state_q   <= START;
                    end
                end
                START: begin
                    if (tx_cnt_q == CNT_MAX) begin
                        tx_cnt_q     <= '0;
                        serial_out_q <= tx_shift_q[0];
                        tx_state_q   <= DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tx_cnt_q == CNT_MAX) begin
                        tx_cnt_q   <= '0;
                        // Bit 0 of the shift register is always the bit on
                        // the line, so the next bit is bit 1.
                        tx_shift_q <= tx_shift_q >> 1;
                        if (tx_bit_q == 3'd7) begin
                            serial_out_q <= 1'b1;
                            tx_state_q   <= STOP;
                        end else begin
                            tx_bit_q     <= tx_bit_q + 3'd1;
                            serial_out_q <= tx_shift_q[1];
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (tx_cnt_q == CNT_MAX) begin
                        tx_cnt_q    <= '0;
                        tx_busy_q   <= 1'b0;
                        char_sent_q <= 1'b1;
                        tx_state_q  <= IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                default: tx_state_q <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic [1:0]    sync_q;
    logic          rx_line;
    state_t        rx_state_q;
    logic [CW-1:0] rx_cnt_q;
    logic [2:0]    rx_bit_q;
    logic [7:0]    rx_shift_q;
    logic [7:0]    rx_data_q;
    logic          char_rcvd_q;
    logic          overrun_q;
    logic          frame_err_q;

    assign rx_line = sync_q[1];

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync_q      <= 2'b11;
            rx_state_q  <= IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            char_rcvd_q <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], serial_in};

            // Processor read clears the flags; a delivery or framing error in
            // the same cycle overrides this below.
            if (proc.load) begin
                char_rcvd_q <= 1'b0;
                overrun_q   <= 1'b0;
                frame_err_q <= 1'b0;
            end

            case (rx_state_q)
                IDLE: begin
                    if (!rx_line) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= START;
                    end
                end
                START: begin
                    if (rx_cnt_q == MID_M1) begin
                        rx_cnt_q <= '0;
                        if (!rx_line) begin
                            rx_bit_q   <= '0;
                            rx_state_q <= DATA;
                        end else begin
                            // Line returned high: a glitch, not a start bit.
                            rx_state_q <= IDLE;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (rx_cnt_q == CNT_MAX) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_line, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) begin
                            rx_state_q <= STOP;
                        end else begin
                            rx_bit_q <= rx_bit_q + 3'd1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (rx_cnt_q == CNT_MAX) begin
                        // Leave mid-stop-bit so the next start edge is seen.
                        rx_cnt_q   <= '0;
                        rx_state_q <= IDLE;
                        if (rx_line) begin
                            rx_data_q   <= rx_shift_q;
                            char_rcvd_q <= 1'b1;
                            if (char_rcvd_q && !proc.load) begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                default: rx_state_q <= IDLE;
            endcase
        end
    end

    assign serial_out              = serial_out_q;
    assign proc.tx_busy            = tx_busy_q;
    assign proc.character_sent     = char_sent_q;
    assign proc.rx_data            = rx_data_q;
    assign proc.character_received = char_rcvd_q;
    assign proc.rx_overrun         = overrun_q;
    assign proc.framing_error      = frame_err_q;

endmodule

// File: tb/tb_serial_link_controller.sv
module tb_serial_link_controller;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic serial_in;
    logic serial_out;

    always #5 clk = ~clk;

    serial_link_controller_if io ();

    serial_link_controller #(.CLKS_PER_BIT(CPB)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .proc          (io.slave),
        .serial_in     (serial_in),
        .serial_out    (serial_out)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model of the processor-visible receive state.
    logic [7:0] m_data;
    bit         m_crcv, m_ovr, m_ferr;
    int         cal_k = -1;         // loop index of the delivery edge within a frame
    int         last_deliver_k;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_rx_state(input string tag);
        check({tag, "_data"}, 32'(io.rx_data), 32'(m_data));
        check({tag, "_crcv"}, 32'(io.character_received), 32'(m_crcv));
        check({tag, "_ovr"},  32'(io.rx_overrun), 32'(m_ovr));
        check({tag, "_ferr"}, 32'(io.framing_error), 32'(m_ferr));
    endtask

    // Sends one byte on the transmitter and checks each bit at its centre.
    // k counts falling edges after the edge that sampled transmit_enable.
    task automatic tx_frame(input logic [7:0] d, input bit hold);
        logic [9:0] fr;
        int sent_at, pulses;
        fr = {1'b1, d, 1'b0};
        sent_at = -1;
        pulses  = 0;
        io.tx_data = d;
        io.transmit_enable = 1'b1;
        @(negedge clk);
        check("tx_busy", 32'(io.tx_busy), 32'd1);
        io.tx_data = 8'($urandom);
        for (int k = 0; k < 176; k++) begin
            if (!hold || k >= 150) io.transmit_enable = 1'b0;
            if (k % CPB == CPB / 2 && k < 10 * CPB)
                check("tx_bit", 32'(serial_out), 32'(fr[k / CPB]));
            if (io.character_sent) begin
                pulses++;
                if (sent_at < 0) sent_at = k;
            end
            @(negedge clk);
        end
        io.transmit_enable = 1'b0;
        // Pulse appears after the 161st rising edge counting the sampling edge.
        check("tx_sent_at", 32'(sent_at), 32'd160);
        check("tx_pulses", 32'(pulses), 32'd1);
        check("tx_idle", 32'(io.tx_busy), 32'd0);
        check("tx_line_idle", 32'(serial_out), 32'd1);
    endtask

    // Drives one frame into serial_in; load_at selects a loop index at which
    // load is pulsed (-1 for none).
    task automatic rx_send(input logic [7:0] d, input bit stop_ok, input int load_at);
        logic [9:0] fr;
        logic [7:0] prev;
        bit seen, ld_del;
        fr   = {stop_ok, d, 1'b0};
        prev = io.rx_data;
        seen = 0;
        last_deliver_k = -1;
        for (int k = 0; k < 10 * CPB; k++) begin
            serial_in = fr[k / CPB];
            io.load   = (k == load_at);
            @(negedge clk);
            if (!seen && io.rx_data !== prev) begin
                seen = 1;
                last_deliver_k = k;
            end
        end
        io.load   = 1'b0;
        serial_in = 1'b1;
        repeat (CPB) @(negedge clk);
        ld_del = (load_at >= 0) && (load_at == cal_k);
        if (stop_ok) begin
            if (m_crcv && !ld_del) m_ovr = 1;
            if (ld_del) begin
                m_ovr  = 0;
                m_ferr = 0;
            end
            m_data = d;
            m_crcv = 1;
        end else begin
            m_ferr = 1;
        end
    endtask

    task automatic do_load();
        io.load = 1'b1;
        @(negedge clk);
        io.load = 1'b0;
        m_crcv = 0;
        m_ovr  = 0;
        m_ferr = 0;
        check_rx_state("load");
    endtask

    task automatic model_reset();
        m_data = 8'h00;
        m_crcv = 0;
        m_ovr  = 0;
        m_ferr = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rr;
        logic [9:0] fr;
        rst_n = 1'b0;
        serial_in = 1'b1;
        io.tx_data = 8'h00;
        io.transmit_enable = 1'b0;
        io.load = 1'b0;
        model_reset();
        #12;
        check("rst_line", 32'(serial_out), 32'd1);
        check("rst_busy", 32'(io.tx_busy), 32'd0);
        check("rst_sent", 32'(io.character_sent), 32'd0);
        check_rx_state("rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_rx_state("post_rst");

        // Transmit: 0xA5 with transmit_enable held through the frame
        tx_frame(8'hA5, 1'b1);
        repeat (4) tx_frame(8'($urandom), 1'b0);

        // Receive 0x3C, calibrate delivery timing, hold until load
        rx_send(8'h3C, 1'b1, -1);
        cal_k = last_deliver_k;
        check("rx_cal_seen", 32'(cal_k >= 0), 32'd1);
        check_rx_state("rx_3c");
        repeat (20) @(negedge clk);
        check("rx_3c_hold", 32'(io.character_received), 32'd1);
        do_load();

        // Overrun: two frames without load
        rx_send(8'h11, 1'b1, -1);
        rx_send(8'h22, 1'b1, -1);
        check_rx_state("rx_ovr");
        do_load();

        // Load coinciding with delivery of a second byte
        rx_send(8'h44, 1'b1, -1);
        rx_send(8'h88, 1'b1, cal_k);
        check_rx_state("rx_ld_del");

        // Framing error, then a valid byte
        rx_send(8'h55, 1'b0, -1);
        check_rx_state("rx_ferr");
        rx_send(8'h66, 1'b1, -1);
        check_rx_state("rx_66");
        do_load();

        // Short low glitch must not start a frame
        serial_in = 1'b0;
        repeat (5) @(negedge clk);
        serial_in = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check_rx_state("glitch");
        rx_send(8'h9A, 1'b1, -1);
        check_rx_state("post_glitch");

        // Randomized receive traffic
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 2) == 0) do_load();
            rx_send(8'($urandom), ($urandom_range(0, 3) != 0), -1);
            check_rx_state("rx_rand");
        end

        // Make sure flags are set before the mid-frame reset
        rx_send(8'h77, 1'b1, -1);
        rx_send(8'h12, 1'b0, -1);
        check_rx_state("pre_rst");

        // Reset during TX bit 4 and RX bit 3
        rr = 8'($urandom);
        fr = {1'b1, rr, 1'b0};
        io.tx_data = 8'($urandom);
        io.transmit_enable = 1'b1;
        @(negedge clk);
        io.transmit_enable = 1'b0;
        for (int k = 0; k < 5 * CPB + CPB / 2; k++) begin
            if (k >= CPB) serial_in = fr[(k - CPB) / CPB];
            @(negedge clk);
        end
        rst_n = 1'b0;
        serial_in = 1'b1;
        #1;
        model_reset();
        check("mid_rst_line", 32'(serial_out), 32'd1);
        check("mid_rst_busy", 32'(io.tx_busy), 32'd0);
        check("mid_rst_sent", 32'(io.character_sent), 32'd0);
        check_rx_state("mid_rst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tx_frame(8'($urandom), 1'b0);
        rx_send(8'hC3, 1'b1, -1);
        check_rx_state("post_mid_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
